pipe_reader: RTL and testbench
==============================

Name: pipe_reader

Overview:
- Read-side initiator for the generic `pipe` block.
- On a `start` pulse it drives the pipe read handshake and fetches exactly one frame of `LINE_WIDTH*FRAME_HEIGHT` words.
- Words go through a 2-entry holding buffer and out to the downstream pixel consumer on a valid/ready stream, tagged with end-of-line and end-of-frame flags.
- Position: between the pipe and the first vision-processing stage.

Parameters:
DATA_WIDTH, 18, width of pipe words and output data
LINE_WIDTH, 640, words per line (>=2)
FRAME_HEIGHT, 480, lines per frame (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a frame fetch (honoured only in IDLE)
pipe_read_req  output  1  read request to pipe
pipe_read_ack  input  1  pipe acknowledges; word transferred in any cycle with req&&ack
pipe_read_data  input  DATA_WIDTH  pipe word, valid when pipe_read_ack=1
out_valid  output  1  head of buffer valid
out_ready  input  1  downstream accepts head when out_valid&&out_ready
out_data  output  DATA_WIDTH  head word
out_eol  output  1  head word is last of a line
out_eof  output  1  head word is last of the frame
busy  output  1  high in FETCH and DRAIN
frame_done  output  1  one-cycle pulse when the final word has been popped

Behaviour:
- Clock and reset: one clock (`clk`); reset (`rst`) is synchronous, active-high. All state is updated only on the rising edge of `clk`.
- Reset values:
  - All outputs are 0.
  - State = IDLE; buffer empty (count=0).
  - Column, row and fetched counters = 0.
- Reset mid-frame: buffered words are discarded and no `frame_done` is issued.
- Counter widths: `$clog2` of their range; the fetched counter spans `LINE_WIDTH*FRAME_HEIGHT`.
- State machine (IDLE, FETCH, DRAIN):
  - IDLE: `pipe_read_req`=0 and `busy`=0. `start`=1 → FETCH at the next edge, with counters cleared.
  - FETCH:
    - `pipe_read_req` = (count<2) && (fetched < total). This is combinational from registered state only; it never depends on `pipe_read_ack`.
    - Accepting the last word (fetched == total-1, with req&&ack) → DRAIN.
  - DRAIN:
    - `pipe_read_req`=0.
    - When the word with `out_eof`=1 is popped → IDLE at that edge, and `frame_done`=1 for exactly the following cycle.
  - `start` in FETCH or DRAIN is ignored; no queuing.
- Pipe handshake:
  - A transfer happens only in a cycle with `pipe_read_req`=1 && `pipe_read_ack`=1. `pipe_read_data` is captured at that edge.
  - `pipe_read_ack` while `pipe_read_req`=0 is ignored; nothing is captured.
  - `pipe_read_req` may stay high across consecutive acks, giving 1 word/cycle.
- Tagging at capture:
  - eol = (col == LINE_WIDTH-1).
  - eof = eol && (row == FRAME_HEIGHT-1).
  - col wraps to 0 on eol; row increments on eol.
- Buffer:
  - 2-entry FIFO; head is driven on `out_data`/`out_eol`/`out_eof`.
  - Latency: an ack in cycle N with the buffer empty gives `out_valid`=1 in cycle N+1.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Full (count=2): `pipe_read_req`=0, so there is no overflow path.
  - Empty: `out_valid`=0; `out_data` keeps its last value.
  - While `out_valid`&&!`out_ready`, the head data and flags are held stable.
- Throughput: 1 word/cycle when ack and ready are both continuously high.

Test Plan:
All scenarios use LINE_WIDTH=4, FRAME_HEIGHT=2 (8 words).

1. Reset, then idle 5 cycles:
   - `pipe_read_req`=0, `out_valid`=0, `busy`=0, `frame_done`=0 throughout.
   - A pulse of `pipe_read_ack` with data 7 produces no output.
2. Streaming frame: `start` pulse; ack held high with data 1..8; `out_ready`=1.
   - `out_data` 1..8 on consecutive cycles, first appearing one cycle after the first ack.
   - `out_eol`=1 on words 4 and 8; `out_eof`=1 on 8 only.
   - `frame_done` pulses once, in the cycle after 8 is popped; `busy` then drops.
3. Backpressure: `out_ready`=0 during a frame.
   - After 2 words are captured, `pipe_read_req` drops and `out_data` holds 1.
   - Raising ready drains 1,2 and requesting resumes; no word is lost or duplicated.
4. Sparse ack: ack every 3rd cycle with data 10..17, `out_ready`=1.
   - Output sequence is 10..17 with the eol/eof positions of scenario 2.
   - `pipe_read_req` stays high between acks.
5. `start` asserted again mid-FETCH and in DRAIN:
   - Ignored; exactly 8 words are fetched.
   - A fresh `start` after `frame_done` fetches a second frame whose first word has `out_eol`=0 (counters reset).
6. `rst` asserted after 5 words: next cycle all outputs are 0 and state is IDLE; no `frame_done`; a following `start` restarts a full 8-word frame.

Source files
------------

// File: rtl/pipe_reader.sv
// Read-side initiator for the pipe block: fetches one frame of LINE_WIDTH*FRAME_HEIGHT
// words and streams them out through a 2-entry buffer with end-of-line/frame tags.
module pipe_reader #(
    parameter int DATA_WIDTH   = 18,
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  pipe_read_req,
    input  logic                  pipe_read_ack,
    input  logic [DATA_WIDTH-1:0] pipe_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int TOTAL = LINE_WIDTH * FRAME_HEIGHT;
    localparam int COL_W = $clog2(LINE_WIDTH);
    localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int CNT_W = $clog2(TOTAL + 1);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [CNT_W-1:0] TOTAL_N    = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_INDEX = CNT_W'(TOTAL - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] fetched_q, fetched_d;
    logic [1:0]       count_q, count_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             frame_done_q, frame_done_d;

    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [1:0]            buf_eol_q;
    logic [1:0]            buf_eof_q;

    logic push;
    logic pop;
    logic tag_eol;
    logic tag_eof;
    logic head_idx;

    assign pipe_read_req = (state_q == S_FETCH) && (count_q < 2'd2) && (fetched_q < TOTAL_N);
    assign push          = pipe_read_req && pipe_read_ack;
    assign out_valid     = (count_q != 2'd0);
    assign pop           = out_valid && out_ready;
    assign tag_eol       = (col_q == COL_LAST);
    assign tag_eof       = tag_eol && (row_q == ROW_LAST);

    // When empty, point at the slot popped last so the output word holds its value.
    assign head_idx   = out_valid ? rd_ptr_q : ~rd_ptr_q;
    assign out_data   = buf_data_q[head_idx];
    assign out_eol    = buf_eol_q[head_idx];
    assign out_eof    = buf_eof_q[head_idx];
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        fetched_d    = fetched_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    col_d     = '0;
                    row_d     = '0;
                    fetched_d = '0;
                end
            end
            S_FETCH: begin
                if (push) begin
                    fetched_d = fetched_q + 1'b1;
                    col_d     = tag_eol ? '0 : col_q + 1'b1;
                    if (tag_eol) row_d = row_q + 1'b1;
                    if (fetched_q == LAST_INDEX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && out_eof) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            fetched_q    <= '0;
            count_q      <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            fetched_q    <= fetched_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the two buffer slots are reset because they drive the outputs directly, which must read 0 after reset.
        if (rst) begin
            for (int i = 0; i < 2; i++) buf_data_q[i] <= '0;
            buf_eol_q <= '0;
            buf_eof_q <= '0;
        end else if (push) begin
            buf_data_q[wr_ptr_q] <= pipe_read_data;
            buf_eol_q[wr_ptr_q]  <= tag_eol;
            buf_eof_q[wr_ptr_q]  <= tag_eof;
        end
    end

endmodule

// File: tb/tb_pipe_reader.sv
// Self-checking bench for pipe_reader with a 4x2 frame: a directed vector table for
// the streaming frame plus hand-written sequences for the multi-cycle corner cases.
module tb_pipe_reader;

    localparam int DW    = 18;
    localparam int LW    = 4;
    localparam int FH    = 2;
    localparam int TOTAL = LW * FH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pipe_read_req;
    logic          pipe_read_ack;
    logic [DW-1:0] pipe_read_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_eol;
    logic          out_eof;
    logic          busy;
    logic          frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_reader #(
        .DATA_WIDTH  (DW),
        .LINE_WIDTH  (LW),
        .FRAME_HEIGHT(FH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pipe_read_req (pipe_read_req),
        .pipe_read_ack (pipe_read_ack),
        .pipe_read_data(pipe_read_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_eol       (out_eol),
        .out_eof       (out_eof),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic          ack;
        logic [DW-1:0] data;
        logic          ready;
        logic          req;
        logic          valid;
        logic [DW-1:0] odata;
        logic          eol;
        logic          eof;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit st, input bit ak, input int d, input bit rd,
                                input bit rq, input bit vl, input int od,
                                input bit el, input bit ef, input bit bs, input bit dn);
        vec_t v;
        v.start = st; v.ack = ak; v.data = DW'(d); v.ready = rd;
        v.req = rq; v.valid = vl; v.odata = DW'(od);
        v.eol = el; v.eof = ef; v.busy = bs; v.done = dn;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame with words base..base+7; ack every ack_period cycles, ready low for
    // the first ready_low cycles; restart pulses start once mid-FETCH and once in DRAIN.
    task automatic run_frame(input int base, input int ack_period, input int ready_low,
                             input bit restart);
        int pushed = 0;
        int popped = 0;
        bit done_next = 1'b0;
        bit finished = 1'b0;
        bit exp_req;
        bit exp_valid;
        step();
        start = 1'b1; pipe_read_ack = 1'b0; out_ready = (ready_low == 0);
        @(negedge clk);
        check("start_from_idle", {busy, pipe_read_req, frame_done}, 3'b000);
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            step();
            start          = restart && ((cyc == 3) || (pushed == TOTAL && popped < TOTAL));
            pipe_read_ack  = ((cyc % ack_period) == 0);
            pipe_read_data = DW'(base + pushed);
            out_ready      = (cyc >= ready_low);
            @(negedge clk);
            if (done_next) begin
                check("done_pulse", {frame_done, busy, pipe_read_req, out_valid}, 4'b1000);
                finished = 1'b1;
            end else begin
                exp_req   = (pushed < TOTAL) && (pushed - popped < 2);
                exp_valid = (pushed - popped) > 0;
                check("req", pipe_read_req, exp_req);
                check("valid", out_valid, exp_valid);
                check("busy_done", {busy, frame_done}, 2'b10);
                if (exp_valid)
                    check("head", {out_data, out_eol, out_eof},
                          {DW'(base + popped), (popped % LW) == LW - 1, popped == TOTAL - 1});
                if (exp_valid && out_ready) begin
                    if (popped == TOTAL - 1) done_next = 1'b1;
                    popped++;
                end
                if (exp_req && pipe_read_ack) pushed++;
            end
        end
        if (!finished) check("frame_timeout", 1, 0);
        step();
        start = 1'b0; pipe_read_ack = 1'b0;
        @(negedge clk);
        check("after_frame", {frame_done, busy, pipe_read_req, out_valid}, 4'b0000);
    endtask

    initial begin
        logic [23:0] act;
        logic [23:0] exp;

        // Scenario 1: reset and idle; a stray ack is ignored.
        rst = 1'b1; start = 1'b0; pipe_read_ack = 1'b0; pipe_read_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {pipe_read_req, out_valid, out_data, out_eol, out_eof, busy, frame_done}, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle_%0d", i), {pipe_read_req, out_valid, busy, frame_done}, 4'b0000);
            step();
        end
        pipe_read_ack = 1'b1; pipe_read_data = DW'(7);
        @(negedge clk);
        check("idle_ack_req", pipe_read_req, 1'b0);
        step();
        pipe_read_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_no_output", {out_valid, out_data, busy}, 0);

        // Scenario 2: streaming frame, one word per cycle.
        vecs[0]  = mk(1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 1,  1, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(0, 1, 2, 1,  1, 1, 1, 0, 0, 1, 0);
        vecs[3]  = mk(0, 1, 3, 1,  1, 1, 2, 0, 0, 1, 0);
        vecs[4]  = mk(0, 1, 4, 1,  1, 1, 3, 0, 0, 1, 0);
        vecs[5]  = mk(0, 1, 5, 1,  1, 1, 4, 1, 0, 1, 0);
        vecs[6]  = mk(0, 1, 6, 1,  1, 1, 5, 0, 0, 1, 0);
        vecs[7]  = mk(0, 1, 7, 1,  1, 1, 6, 0, 0, 1, 0);
        vecs[8]  = mk(0, 1, 8, 1,  1, 1, 7, 0, 0, 1, 0);
        vecs[9]  = mk(0, 1, 8, 1,  0, 1, 8, 1, 1, 1, 0);
        vecs[10] = mk(0, 0, 0, 1,  0, 0, 8, 0, 0, 0, 1);
        vecs[11] = mk(0, 0, 0, 1,  0, 0, 8, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            start          = vecs[i].start;
            pipe_read_ack  = vecs[i].ack;
            pipe_read_data = vecs[i].data;
            out_ready      = vecs[i].ready;
            @(negedge clk);
            act = {pipe_read_req, out_valid, out_data, out_eol & out_valid, out_eof & out_valid,
                   busy, frame_done};
            exp = {vecs[i].req, vecs[i].valid, vecs[i].odata, vecs[i].eol & vecs[i].valid,
                   vecs[i].eof & vecs[i].valid, vecs[i].busy, vecs[i].done};
            check($sformatf("stream_%0d", i), act, exp);
        end

        // Scenario 3: backpressure fills the buffer, then drains.
        run_frame(1, 1, 6, 1'b0);
        // Scenario 4: sparse acks every third cycle.
        run_frame(10, 3, 0, 1'b0);
        // Scenario 5: start ignored mid-FETCH and in DRAIN, then a fresh frame.
        run_frame(20, 1, 0, 1'b1);
        run_frame(50, 2, 0, 1'b0);

        // Scenario 6: reset after five words, then a full restart.
        step();
        start = 1'b1; pipe_read_ack = 1'b0; out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            start = 1'b0; pipe_read_ack = 1'b1; pipe_read_data = DW'(k);
        end
        step();
        pipe_read_ack = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs",
              {pipe_read_req, out_valid, out_data, out_eol, out_eof, busy, frame_done}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check($sformatf("mid_reset_quiet_%0d", i), {frame_done, busy, out_valid}, 3'b000);
        end
        run_frame(60, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
